// File: rtl/demux_lane_collector.sv
// Collects bits from the four 1:4 demux lanes into per-lane W-bit words and
// streams completed words out through one valid/ready port, arbitrated round-robin.
module demux_lane_collector #(
  parameter int W         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [1:0]   sel,
  input  logic         a,
  input  logic         b,
  input  logic         c,
  input  logic         d,
  input  logic         clr_ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_chan,
  output logic [3:0]   overflow
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  r_sr [4];
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    r_full;
  logic [1:0]    r_ptr;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [1:0]    r_out_chan;
  logic [3:0]    r_ovf;

  logic       w_bit;
  logic       w_load;
  logic       w_gnt_vld;
  logic [1:0] w_gnt;
  logic [1:0] w_idx;
  logic [3:0] w_deq;
  logic [3:0] w_acc;
  logic [3:0] w_drop;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign overflow  = r_ovf;

  always_comb begin
    w_bit = 1'b0;
    case (sel)
      2'd0:    w_bit = a;
      2'd1:    w_bit = b;
      2'd2:    w_bit = c;
      default: w_bit = d;
    endcase
  end

  assign w_load = !r_out_valid || out_ready;

  // First full lane at or after the pointer, scanning cyclically.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = r_ptr;
    w_idx     = r_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_gnt_vld && r_full[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  // A full lane being dequeued this cycle can take the incoming bit as the first bit of its next word.
  always_comb begin
    w_deq  = '0;
    w_acc  = '0;
    w_drop = '0;
    for (int l = 0; l < 4; l++) begin
      w_deq[l]  = w_load && w_gnt_vld && (w_gnt == 2'(l));
      w_acc[l]  = in_valid && (sel == 2'(l)) && (!r_full[l] || w_deq[l]);
      w_drop[l] = in_valid && (sel == 2'(l)) && r_full[l] && !w_deq[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 4; l++) begin
        r_sr[l]  <= '0;
        r_cnt[l] <= '0;
      end
      r_full <= '0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (w_deq[l]) r_full[l] <= 1'b0;
        if (w_acc[l]) begin
          if (LSB_FIRST) r_sr[l] <= {w_bit, r_sr[l][W-1:1]};
          else           r_sr[l] <= {r_sr[l][W-2:0], w_bit};
          if (r_cnt[l] == LAST) begin
            r_cnt[l]  <= '0;
            r_full[l] <= 1'b1;
          end else begin
            r_cnt[l] <= r_cnt[l] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_sr[w_gnt];
        r_out_chan  <= w_gnt;
        r_ptr       <= w_gnt + 2'd1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // A fresh drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= '0;
    else        r_ovf <= (clr_ovf ? 4'b0 : r_ovf) | w_drop;
  end

endmodule
